// File: rtl/systemverilog_str_demux_if.sv
// Stream-in / bus-out link bundle for the byte-stream deserializer.
// The master view belongs to the deserializer; the slave view belongs to its environment.
interface systemverilog_str_demux_if;
    logic        str_vld;
    logic [7:0]  str_bus;
    logic        str_rdy;
    logic        bus_vld;
    logic [31:0] bus_adr;
    logic [31:0] bus_dat;
    logic        bus_rdy;
    logic        err_tmo;

    modport master (
        input  str_vld, str_bus, bus_rdy,
        output str_rdy, bus_vld, bus_adr, bus_dat, err_tmo
    );

    modport slave (
        output str_vld, str_bus, bus_rdy,
        input  str_rdy, bus_vld, bus_adr, bus_dat, err_tmo
    );
endinterface

// File: rtl/systemverilog_str_demux.sv
// Deserializes an 8-bit valid/ready byte stream into 32-bit address/data bus writes.
// One assembly buffer plus the output registers give double buffering against bus_rdy.
module systemverilog_str_demux #(
    parameter int unsigned TMO = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    systemverilog_str_demux_if.master   link
);

    localparam logic [15:0] TMO_LAST = 16'(TMO - 1);
    localparam bit          TMO_EN   = (TMO != 0);

    logic [63:0] asm_q, asm_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        pend_q, pend_d;
    logic [15:0] tmo_cnt_q, tmo_cnt_d;
    logic        bus_vld_q, bus_vld_d;
    logic [31:0] bus_adr_q, bus_adr_d;
    logic [31:0] bus_dat_q, bus_dat_d;

    logic str_trn, bus_trn, out_free, tmo_hit;

    assign str_trn  = link.str_vld & ~pend_q;
    assign bus_trn  = bus_vld_q & link.bus_rdy;
    assign out_free = ~bus_vld_q | link.bus_rdy;

    // A byte arriving on the expiry cycle wins over the timeout.
    assign tmo_hit  = TMO_EN && !str_trn && (cnt_q != 3'd0) && !pend_q
                      && (tmo_cnt_q == TMO_LAST);

    assign link.str_rdy = ~pend_q;
    assign link.bus_vld = bus_vld_q;
    assign link.bus_adr = bus_adr_q;
    assign link.bus_dat = bus_dat_q;
    assign link.err_tmo = tmo_hit;

    always_comb begin
        // NOTE: every next-state variable gets its hold value first so no path infers a latch.
        asm_d     = asm_q;
        cnt_d     = cnt_q;
        pend_d    = pend_q;
        bus_vld_d = bus_vld_q;
        bus_adr_d = bus_adr_q;
        bus_dat_d = bus_dat_q;

        if (bus_trn) begin
            bus_vld_d = 1'b0;
        end

        if (pend_q && bus_trn) begin
            bus_vld_d = 1'b1;
            bus_adr_d = asm_q[31:0];
            bus_dat_d = asm_q[63:32];
            pend_d    = 1'b0;
        end

        if (str_trn) begin
            asm_d[{cnt_q, 3'b000} +: 8] = link.str_bus;
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
                if (out_free) begin
                    // Byte 7 bypasses the assembly register for single-cycle latency.
                    bus_vld_d = 1'b1;
                    bus_adr_d = asm_q[31:0];
                    bus_dat_d = {link.str_bus, asm_q[55:32]};
                end else begin
                    pend_d = 1'b1;
                end
            end
        end else if (tmo_hit) begin
            cnt_d = 3'd0;
        end

        if (str_trn || (cnt_q == 3'd0) || pend_q || tmo_hit) begin
            tmo_cnt_d = 16'd0;
        end else begin
            tmo_cnt_d = tmo_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the assembly buffer is reset too; it is one register, not a RAM, and a clean
            // value keeps partially written lanes deterministic after reset.
            asm_q     <= '0;
            cnt_q     <= '0;
            pend_q    <= 1'b0;
            tmo_cnt_q <= '0;
            bus_vld_q <= 1'b0;
            bus_adr_q <= '0;
            bus_dat_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the same pre-edge state.
            asm_q     <= asm_d;
            cnt_q     <= cnt_d;
            pend_q    <= pend_d;
            tmo_cnt_q <= tmo_cnt_d;
            bus_vld_q <= bus_vld_d;
            bus_adr_q <= bus_adr_d;
            bus_dat_q <= bus_dat_d;
        end
    end

endmodule

// File: tb/tb_systemverilog_str_demux.sv
// Scoreboard bench: stimulus pushes expected {adr,dat}; a negedge monitor pops on every bus transfer.
module tb_systemverilog_str_demux;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    systemverilog_str_demux_if link ();

    systemverilog_str_demux #(.TMO(16)) dut (
        .clk  (clk),
        .rst  (rst),
        .link (link)
    );

    int          checks = 0;
    int          errors = 0;
    logic [63:0] exp_q[$];
    int          trn_cyc[$];
    int          cyc = 0;
    int          tmo_pulses = 0;
    bit          rdy_dropped = 0;
    bit          prev_stall = 0;
    bit          rst_seen = 0;
    logic [63:0] prev_pkt;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) cyc++;
    always @(posedge rst) rst_seen = 1'b1;

    // Monitor: scoreboard pops, hold-stability under back-pressure, pulse counting.
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (!link.str_rdy) rdy_dropped = 1'b1;
            if (link.err_tmo) tmo_pulses++;
            if (prev_stall && !rst_seen) begin
                check("stall_vld", 64'(link.bus_vld), 64'd1);
                check("stall_hold", {link.bus_adr, link.bus_dat}, prev_pkt);
            end
            if (link.bus_vld && link.bus_rdy) begin
                trn_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL bus_unexpected: got %h expected no transfer",
                             {link.bus_adr, link.bus_dat});
                end else begin
                    check("bus_pkt", {link.bus_adr, link.bus_dat}, exp_q.pop_front());
                end
            end
            prev_stall = link.bus_vld && !link.bus_rdy;
            prev_pkt   = {link.bus_adr, link.bus_dat};
        end
        rst_seen = 1'b0;
    end

    task automatic check_reset(input string tag);
        check({tag, "_rdy_vld_err"}, 64'({link.str_rdy, link.bus_vld, link.err_tmo}), 64'b100);
        check({tag, "_adr_dat"}, {link.bus_adr, link.bus_dat}, 64'd0);
    endtask

    // Called just after a posedge; returns just after the edge that accepted the byte.
    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        link.str_vld = 1'b1;
        link.str_bus = b;
        @(negedge clk);
        while (!link.str_rdy && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!link.str_rdy) begin
            checks++;
            errors++;
            $display("FAIL str_rdy_wait: got str_rdy=0 for %0d cycles expected 1", n);
        end
        @(posedge clk);
        #1;
        link.str_vld = 1'b0;
    endtask

    task automatic send_pkt(input logic [31:0] adr, input logic [31:0] dat, input bit gaps);
        logic [63:0] p;
        p = {dat, adr};
        exp_q.push_back({adr, dat});
        for (int i = 0; i < 8; i++) begin
            send_byte(p[i*8 +: 8]);
            if (gaps && i < 7) begin
                link.str_bus = 8'($urandom);
                @(posedge clk);
                #1;
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int idx;
        rst          = 1'b1;
        link.str_vld = 1'b0;
        link.str_bus = 8'h00;
        link.bus_rdy = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset("reset");
        rst = 1'b0;

        // Single packet, no back-pressure.
        link.bus_rdy = 1'b1;
        rdy_dropped  = 0;
        send_pkt(32'h12345678, 32'hDEADBEEF, 0);
        check("t1_latency_vld", 64'(link.bus_vld), 64'd1);
        @(posedge clk); #1;
        check("t1_vld_drop", 64'(link.bus_vld), 64'd0);
        check("t1_rdy_steady", 64'(rdy_dropped), 64'd0);

        // Back-pressure: A held on the bus, B parked in the assembly buffer.
        link.bus_rdy = 1'b0;
        send_pkt(32'h0000_0010, 32'h0000_0001, 0);
        check("t2_a_vld", 64'(link.bus_vld), 64'd1);
        send_pkt(32'h0000_0020, 32'h0000_0002, 0);
        check("t2_rdy_low", 64'(link.str_rdy), 64'd0);
        check("t2_a_held", {link.bus_adr, link.bus_dat}, {32'h10, 32'h1});
        repeat (3) @(posedge clk);
        #1;
        link.bus_rdy = 1'b1;
        @(posedge clk); #1;
        link.bus_rdy = 1'b0;
        check("t2_b_vld", 64'(link.bus_vld), 64'd1);
        check("t2_b_pkt", {link.bus_adr, link.bus_dat}, {32'h20, 32'h2});
        check("t2_rdy_back", 64'(link.str_rdy), 64'd1);
        link.bus_rdy = 1'b1;
        @(posedge clk); #1;
        check("t2_vld_drop", 64'(link.bus_vld), 64'd0);

        // Back-to-back packets, continuous stream.
        trn_cyc.delete();
        rdy_dropped = 0;
        send_pkt(32'hA000_0001, 32'hB000_0001, 0);
        send_pkt(32'hA000_0002, 32'hB000_0002, 0);
        send_pkt(32'hA000_0003, 32'hB000_0003, 0);
        @(posedge clk); #1;
        check("t3_trn_count", 64'(trn_cyc.size()), 64'd3);
        if (trn_cyc.size() == 3) begin
            check("t3_gap01", 64'(trn_cyc[1] - trn_cyc[0]), 64'd8);
            check("t3_gap12", 64'(trn_cyc[2] - trn_cyc[1]), 64'd8);
        end
        check("t3_rdy_steady", 64'(rdy_dropped), 64'd0);

        // Timeout on a 3-byte partial packet.
        tmo_pulses = 0;
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        idx = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (link.err_tmo) begin
                idx = i;
                break;
            end
        end
        check("t4_tmo_cycle", 64'(idx), 64'd16);
        repeat (20) @(posedge clk);
        #1;
        check("t4_tmo_once", 64'(tmo_pulses), 64'd1);
        check("t4_no_bus", 64'(link.bus_vld), 64'd0);
        send_pkt(32'hCAFE_0001, 32'h0BAD_F00D, 0);
        @(posedge clk); #1;

        // Reset mid-packet, then mid-transaction.
        for (int i = 0; i < 5; i++) send_byte(8'(8'hF0 + i));
        #2 rst = 1'b1;
        #1 check_reset("t5_rst_pkt");
        @(posedge clk); #1;
        rst = 1'b0;
        link.bus_rdy = 1'b0;
        send_pkt(32'h0000_0055, 32'h0000_0066, 0);
        check("t5_stall_vld", 64'(link.bus_vld), 64'd1);
        #2 rst = 1'b1;
        #1 check_reset("t5_rst_bus");
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        link.bus_rdy = 1'b1;
        send_pkt(32'h0000_0077, 32'h0000_0088, 0);
        @(posedge clk); #1;

        // Stall gaps with junk on str_bus while invalid.
        send_pkt(32'h12345678, 32'hDEADBEEF, 1);
        check("t6_latency_vld", 64'(link.bus_vld), 64'd1);

        repeat (5) @(posedge clk);
        #1;
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/systemverilog_str_demux.md
Name: systemverilog_str_demux

Overview:
- Receiving end of the byte-stream link: deserializes an 8-bit valid/ready stream into bus write transactions.
- Every 8 accepted bytes form one packet (32-bit address, 32-bit data), issued on a valid/ready bus master port.
- Sits at the far end of the stream link, in front of the register/bus fabric.
- Double-buffered: the next packet can be assembled while the previous one waits for bus_rdy.

Parameters:
- TMO, 16, inter-byte timeout in clk cycles for a partially assembled packet.
  - 0 disables the timeout.
  - Legal range 0..65535; the timeout counter is 16 bits.

Ports:
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-high
- str_vld  input  1  stream byte valid
- str_bus  input  8  stream byte
- str_rdy  output  1  stream ready
- bus_vld  output  1  bus transaction valid (chip select)
- bus_adr  output  32  bus address
- bus_dat  output  32  bus write data
- bus_rdy  input  1  bus ready (acknowledge)
- err_tmo  output  1  one-cycle pulse when a partial packet is discarded on timeout

Behaviour:
- Handshakes:
  - Stream byte accepted on a clk edge with str_vld & str_rdy (str_trn).
  - Bus transfer completes on a clk edge with bus_vld & bus_rdy (bus_trn).
- Byte order, fixed:
  - byte0..3 = adr[7:0], adr[15:8], adr[23:16], adr[31:24]
  - byte4..7 = dat[7:0] .. dat[31:24]
- Assembly stage: 64-bit assembly register, 3-bit byte counter cnt (0..7), pend flag (complete packet waiting for the output stage).
  - Each str_trn writes str_bus into byte lane cnt; cnt increments and wraps 7->0.
  - str_rdy = !pend (combinational from the flag).
- Output stage: bus_vld, bus_adr, bus_dat are registers.
  - Output is free when bus_vld==0 or bus_trn occurs in the same cycle.
  - Byte 7 accepted at edge N, output free: bus_adr/bus_dat load the completed packet, including the byte-7 lane taken directly from str_bus; bus_vld=1 after edge N. Latency is 1 clk from last byte to bus_vld.
  - Byte 7 accepted, output not free: pend<=1 and the assembly register holds.
  - While pend, bus_trn at edge M loads output from the assembly register; bus_vld stays 1; pend<=0. str_rdy returns high after edge M, so there is no stream bubble beyond that one cycle.
  - bus_vld, bus_adr, bus_dat stay stable while bus_vld & !bus_rdy; bus_vld drops only after bus_trn when no new packet is loaded.
  - bus_trn and byte-7 acceptance on the same edge: the new packet loads directly, bus_vld stays 1 (back-to-back).
- Timeout (TMO>0): 16-bit counter tmo_cnt.
  - Clears on every str_trn and whenever cnt==0 or pend==1.
  - Otherwise increments each cycle.
  - On reaching TMO-1: cnt<=0, tmo_cnt<=0, err_tmo=1 for exactly one cycle. Partial bytes are discarded; the output stage is unaffected.
  - A str_trn on the timeout cycle takes priority: the byte is accepted and the timeout is cancelled.
- Reset values: str_rdy=1, bus_vld=0, bus_adr=0, bus_dat=0, err_tmo=0, cnt=0, pend=0, tmo_cnt=0.
  - Reset mid-packet or mid-transaction discards all state immediately; no bus transfer is emitted.
- str_bus is ignored when str_vld==0. bus_rdy is ignored when bus_vld==0.

Test Plan:
- Single packet, bus_rdy=1: stream bytes 78 56 34 12 EF BE AD DE on consecutive cycles -> bus_vld=1 for 1 cycle, 1 clk after byte 7, with bus_adr=32'h12345678, bus_dat=32'hDEADBEEF; str_rdy stays 1.
- Back-pressure, bus_rdy=0: send packet A (adr 0x0000_0010, dat 0x1) then packet B (adr 0x0000_0020, dat 0x2).
  - str_rdy=0 after B's byte 7; bus holds A stable.
  - Raise bus_rdy for 1 cycle -> bus shows B the next cycle; str_rdy=1 again.
- Back-to-back with bus_rdy=1 and continuous str_vld: 3 packets in 24 cycles -> 3 bus_trn, 8 cycles apart, str_rdy never drops.
- Timeout, TMO=16: send 3 bytes then idle -> err_tmo pulses once on the 16th idle cycle, bus_vld stays 0.
  - Then send a full 8-byte packet -> its adr/dat are formed from the new bytes only.
- Reset mid-operation: assert rst after byte 5, and again while bus_vld=1 & bus_rdy=0 -> all outputs return to reset values asynchronously; the next full packet decodes correctly.
- Stall gaps: str_vld toggled 1/0 every cycle with random str_bus while invalid -> same result as the single-packet case, with invalid bytes ignored.
